// File: rtl/run_done_ctrl.sv
// ---------------------------------------------------------------------------
// run_done_ctrl
//   Completion side of the testbench Start/Ack program-run handshake.
//   - Tracks one program run. The run begins on the falling edge of Start and
//     ends at the core's halt instruction.
//   - After halt, the PC is held frozen for a short drain window so in-flight
//     writes can land. Ack is then raised to the testbench.
//   - Counts the cycles executed while the PC is enabled.
//   - Forces completion, with Timeout set, when a program runs too long.
//
// Ports
//   Clk           in   system clock; all state changes happen on posedge
//   Reset         in   synchronous, active-high reset
//   Start         in   testbench start request:
//                        high     = load/hold
//                        low seen = begin run
//   CountEn       in   PC counting enable from the PC-enable state bit
//   HaltDetected  in   decoder sees the halt opcode at the current PC (level)
//   Halt          out  freeze PC / suppress writes; low only while running
//   Ack           out  run complete (registered, high only in DONE)
//   Timeout       out  run was ended by MAX_CYCLES (registered)
//   CycleCount    out  counted cycles for the current or last run
// ---------------------------------------------------------------------------
module run_done_ctrl #(
  parameter int unsigned CNT_W        = 16,
  parameter int unsigned MAX_CYCLES   = 40000,
  parameter int unsigned DRAIN_CYCLES = 2
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             CountEn,
  input  logic             HaltDetected,
  output logic             Halt,
  output logic             Ack,
  output logic             Timeout,
  output logic [CNT_W-1:0] CycleCount
);

  // The drain counter only has to reach DRAIN_CYCLES-1.
  // It is kept at least one bit wide so DRAIN_CYCLES==1 stays legal.
  localparam int unsigned DRAIN_CW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  localparam logic [DRAIN_CW-1:0] DRAIN_LAST = DRAIN_CW'(DRAIN_CYCLES - 1);
  localparam logic [DRAIN_CW-1:0] DRAIN_ONE  = DRAIN_CW'(1);
  localparam logic [DRAIN_CW-1:0] DRAIN_ZERO = {DRAIN_CW{1'b0}};

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_SAT  = {CNT_W{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARMED = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t              state_q,       state_d;
  logic [DRAIN_CW-1:0] drain_cnt_q,   drain_cnt_d;
  logic [CNT_W-1:0]    cycle_count_q, cycle_count_d;
  logic                timeout_q,     timeout_d;
  logic                ack_q,         ack_d;

  // Next-state, counter and flag logic
  always_comb begin
    state_d       = state_q;
    drain_cnt_d   = drain_cnt_q;
    cycle_count_d = cycle_count_q;
    timeout_d     = timeout_q;

    case (state_q)
      S_IDLE: begin
        if (Start) begin
          state_d = S_ARMED;
        end else begin
          state_d = S_IDLE;
        end
      end

      // A Start glitch back high simply keeps us here.
      // Only a sampled low level launches the run.
      S_ARMED: begin
        if (!Start) begin
          state_d = S_RUN;
        end else begin
          state_d = S_ARMED;
        end
      end

      S_RUN: begin
        // Saturating count.
        // The cycle that sees the halt or the timeout is itself counted.
        if (CountEn && (cycle_count_q != CNT_SAT)) begin
          cycle_count_d = cycle_count_q + CNT_ONE;
        end else begin
          cycle_count_d = cycle_count_q;
        end

        // Priority: restart > valid halt > runaway limit.
        // Halt is only trusted while the PC is counting.
        if (Start) begin
          state_d = S_ARMED;
        end else if (HaltDetected && CountEn) begin
          state_d     = S_DRAIN;
          drain_cnt_d = DRAIN_ZERO;
        end else if (CountEn && (cycle_count_q == CNT_LAST)) begin
          state_d   = S_DONE;
          timeout_d = 1'b1;
        end else begin
          state_d = S_RUN;
        end
      end

      S_DRAIN: begin
        if (Start) begin
          state_d = S_ARMED;
        end else if (drain_cnt_q == DRAIN_LAST) begin
          state_d = S_DONE;
        end else begin
          state_d     = S_DRAIN;
          drain_cnt_d = drain_cnt_q + DRAIN_ONE;
        end
      end

      S_DONE: begin
        if (Start) begin
          state_d = S_ARMED;
        end else begin
          state_d = S_DONE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Arming a run wipes the results of the previous one.
    // This covers entry from any state; in ARMED the values are already zero.
    if (state_d == S_ARMED) begin
      cycle_count_d = CNT_ZERO;
      timeout_d     = 1'b0;
    end else begin
      cycle_count_d = cycle_count_d;
      timeout_d     = timeout_d;
    end

    // Ack is registered from the next state.
    // It therefore appears on the same edge that enters DONE and drops on the
    // edge that leaves it.
    ack_d = (state_d == S_DONE);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q       <= S_IDLE;
      drain_cnt_q   <= DRAIN_ZERO;
      cycle_count_q <= CNT_ZERO;
      timeout_q     <= 1'b0;
      ack_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      drain_cnt_q   <= drain_cnt_d;
      cycle_count_q <= cycle_count_d;
      timeout_q     <= timeout_d;
      ack_q         <= ack_d;
    end
  end

  // Halt is decoded directly from the state so the PC freezes on the very
  // edge that leaves RUN.
  assign Halt       = (state_q != S_RUN);
  assign Ack        = ack_q;
  assign Timeout    = timeout_q;
  assign CycleCount = cycle_count_q;

endmodule

// File: tb/tb_run_done_ctrl.sv
module tb_run_done_ctrl;

  localparam int CNT_W   = 16;
  localparam int MAX_CYC = 20;
  localparam int DRAIN   = 2;

  logic             Clk = 1'b0;
  logic             Reset = 1'b1;
  logic             Start = 1'b0;
  logic             CountEn = 1'b0;
  logic             HaltDetected = 1'b0;
  logic             Halt;
  logic             Ack;
  logic             Timeout;
  logic [CNT_W-1:0] CycleCount;

  int n_tests = 0;
  int n_fail  = 0;

  run_done_ctrl #(
    .CNT_W       (CNT_W),
    .MAX_CYCLES  (MAX_CYC),
    .DRAIN_CYCLES(DRAIN)
  ) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .Start       (Start),
    .CountEn     (CountEn),
    .HaltDetected(HaltDetected),
    .Halt        (Halt),
    .Ack         (Ack),
    .Timeout     (Timeout),
    .CycleCount  (CycleCount)
  );

  always #5 Clk = ~Clk;

  // Reference model: which phase of the run we are in, how many PC cycles
  // were executed, how many drain cycles remain, and whether the run timed out.
  typedef enum int {M_IDLE, M_ARMED, M_RUN, M_DRAIN, M_DONE} mph_t;

  mph_t m_ph         = M_IDLE;
  int   m_cnt        = 0;
  bit   m_tmo        = 1'b0;
  int   m_drain_left = 0;

  task automatic model_edge(input bit r, input bit s, input bit c, input bit h);
    if (r) begin
      m_ph         = M_IDLE;
      m_cnt        = 0;
      m_tmo        = 1'b0;
      m_drain_left = 0;
    end else if (s && m_ph != M_IDLE && m_ph != M_ARMED) begin
      // Any restart request aborts the run and re-arms.
      m_ph  = M_ARMED;
      m_cnt = 0;
      m_tmo = 1'b0;
    end else begin
      case (m_ph)
        M_IDLE: begin
          if (s) begin
            m_ph  = M_ARMED;
            m_cnt = 0;
            m_tmo = 1'b0;
          end
        end
        M_ARMED: begin
          if (!s) m_ph = M_RUN;
        end
        M_RUN: begin
          if (c && m_cnt < (1 << CNT_W) - 1) m_cnt = m_cnt + 1;
          if (c && h) begin
            m_ph         = M_DRAIN;
            m_drain_left = DRAIN;
          end else if (c && m_cnt == MAX_CYC) begin
            m_ph  = M_DONE;
            m_tmo = 1'b1;
          end
        end
        M_DRAIN: begin
          m_drain_left = m_drain_left - 1;
          if (m_drain_left == 0) m_ph = M_DONE;
        end
        default: ;
      endcase
    end
  endtask

  task automatic check(input string name, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  // One clock: drive inputs at negedge, step the model at posedge, sample 1ns later.
  task automatic cycle(input bit r, input bit s, input bit c, input bit h);
    @(negedge Clk);
    Reset        = r;
    Start        = s;
    CountEn      = c;
    HaltDetected = h;
    @(posedge Clk);
    model_edge(r, s, c, h);
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".halt"}, int'(Halt),       int'(m_ph != M_RUN));
    check({tag, ".ack"},  int'(Ack),        int'(m_ph == M_DONE));
    check({tag, ".tmo"},  int'(Timeout),    int'(m_tmo));
    check({tag, ".cnt"},  int'(CycleCount), m_cnt);
  endtask

  typedef struct {
    bit r;
    bit s;
    bit c;
    bit h;
    bit e_halt;
    bit e_ack;
    bit e_tmo;
    int e_cnt;
  } vec_t;

  vec_t tbl[16];

  initial begin
    int start_hold;
    bit rr, ss, cc, hh;

    // Columns: rst start cen hd | halt ack tmo cnt (values after the edge).
    tbl[0]  = '{1, 0, 0, 0, 1, 0, 0, 0};  // reset
    tbl[1]  = '{1, 1, 0, 0, 1, 0, 0, 0};  // reset beats start
    tbl[2]  = '{0, 1, 0, 0, 1, 0, 0, 0};  // ARMED
    tbl[3]  = '{0, 1, 0, 0, 1, 0, 0, 0};  // hold ARMED
    tbl[4]  = '{0, 0, 1, 0, 0, 0, 0, 0};  // enter RUN, nothing counted yet
    tbl[5]  = '{0, 0, 1, 0, 0, 0, 0, 1};
    tbl[6]  = '{0, 0, 0, 1, 0, 0, 0, 1};  // halt ignored with CountEn=0
    tbl[7]  = '{0, 0, 1, 0, 0, 0, 0, 2};
    tbl[8]  = '{0, 0, 1, 1, 1, 0, 0, 3};  // halt -> DRAIN, cycle counted
    tbl[9]  = '{0, 0, 1, 1, 1, 0, 0, 3};  // DRAIN: no counting
    tbl[10] = '{0, 0, 0, 0, 1, 1, 0, 3};  // DONE
    tbl[11] = '{0, 0, 0, 0, 1, 1, 0, 3};
    tbl[12] = '{0, 1, 0, 0, 1, 0, 0, 0};  // re-arm clears
    tbl[13] = '{0, 1, 0, 0, 1, 0, 0, 0};
    tbl[14] = '{0, 0, 0, 0, 0, 0, 0, 0};  // RUN
    tbl[15] = '{1, 0, 0, 0, 1, 0, 0, 0};  // reset mid-run

    for (int i = 0; i < 16; i++) begin
      cycle(tbl[i].r, tbl[i].s, tbl[i].c, tbl[i].h);
      check($sformatf("vec%0d.halt", i), int'(Halt),       int'(tbl[i].e_halt));
      check($sformatf("vec%0d.ack", i),  int'(Ack),        int'(tbl[i].e_ack));
      check($sformatf("vec%0d.tmo", i),  int'(Timeout),    int'(tbl[i].e_tmo));
      check($sformatf("vec%0d.cnt", i),  int'(CycleCount), tbl[i].e_cnt);
    end

    // Normal run, halt on the 10th RUN cycle, two drain cycles.
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
    check_model("t2.reset");
    for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0);
    cycle(0, 0, 1, 0);
    for (int i = 1; i <= 10; i++) begin
      cycle(0, 0, 1, (i == 10));
      check_model($sformatf("t2.run%0d", i));
    end
    check("t2.cnt_at_halt", int'(CycleCount), 10);
    check("t2.halt_at_halt", int'(Halt), 1);
    check("t2.ack_at_halt", int'(Ack), 0);
    cycle(0, 0, 0, 0);
    check("t2.ack_drain1", int'(Ack), 0);
    cycle(0, 0, 0, 0);
    check("t2.ack_done", int'(Ack), 1);
    check("t2.tmo_done", int'(Timeout), 0);
    check("t2.cnt_done", int'(CycleCount), 10);

    // Runaway program: forced completion after MAX_CYC counted cycles.
    cycle(0, 1, 0, 0);
    cycle(0, 0, 1, 0);
    for (int i = 1; i <= MAX_CYC; i++) begin
      cycle(0, 0, 1, 0);
      check_model($sformatf("t3.run%0d", i));
      if (i == MAX_CYC - 1) begin
        check("t3.halt_before_limit", int'(Halt), 0);
        check("t3.cnt_before_limit", int'(CycleCount), MAX_CYC - 1);
      end
    end
    check("t3.ack", int'(Ack), 1);
    check("t3.tmo", int'(Timeout), 1);
    check("t3.cnt", int'(CycleCount), MAX_CYC);
    cycle(0, 0, 1, 1);
    check("t3.hold_cnt", int'(CycleCount), MAX_CYC);
    check("t3.hold_tmo", int'(Timeout), 1);

    // Start from DONE clears everything; a second run then completes normally.
    cycle(0, 1, 0, 0);
    check("t6.ack_drop", int'(Ack), 0);
    check("t6.cnt_clr", int'(CycleCount), 0);
    check("t6.tmo_clr", int'(Timeout), 0);
    cycle(0, 1, 0, 0);
    cycle(0, 0, 1, 0);
    for (int i = 1; i <= 5; i++) cycle(0, 0, 1, (i == 5));
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    check_model("t6.done");
    check("t6.ack2", int'(Ack), 1);
    check("t6.cnt2", int'(CycleCount), 5);

    // CountEn toggling; halt pulses while CountEn=0 must be ignored.
    cycle(0, 1, 0, 0);
    cycle(0, 0, 0, 0);
    for (int i = 0; i < 12; i++) begin
      cycle(0, 0, (i % 2 == 0), (i % 2 != 0));
      check_model($sformatf("t4.c%0d", i));
    end
    check("t4.still_run", int'(Halt), 0);
    check("t4.cnt", int'(CycleCount), 6);

    // Reset during the first DRAIN cycle: no Ack ever.
    cycle(0, 0, 1, 1);
    check("t5.in_drain", int'(Halt), 1);
    cycle(1, 0, 0, 0);
    check("t5.ack", int'(Ack), 0);
    check("t5.cnt", int'(CycleCount), 0);
    check("t5.halt", int'(Halt), 1);
    for (int i = 0; i < 4; i++) begin
      cycle(0, 0, 0, 0);
      check_model($sformatf("t5.after%0d", i));
    end

    // Randomized traffic against the model.
    start_hold = 0;
    for (int i = 0; i < 3000; i++) begin
      rr = ($urandom_range(0, 99) == 0);
      if (start_hold == 0 && $urandom_range(0, 29) == 0) start_hold = $urandom_range(1, 4);
      ss = (start_hold > 0);
      if (start_hold > 0) start_hold--;
      cc = ($urandom_range(0, 3) != 0);
      hh = ($urandom_range(0, 39) == 0);
      cycle(rr, ss, cc, hh);
      check_model($sformatf("rnd%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
